// File: rtl/enemy_path_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : enemy_path_gen_pkg
// Description : Shared types, constants and helpers for the multi-enemy
//               formation path generator.
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_path_gen_pkg;

  // Width of the level input port.
  localparam int unsigned LEVEL_W = 4;

  // Offset between the x and y images of the built-in path ROM.
  localparam int unsigned PATH_Y_BIAS = 1000;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_t;

  // Map a raw level request onto 1..max_level (0 behaves as level 1).
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl,
                                                      input int unsigned max_level);
    logic [LEVEL_W-1:0] r;
    if (lvl == '0) begin
      r = LEVEL_W'(1);
    end else if (32'(lvl) > max_level) begin
      r = LEVEL_W'(max_level);
    end else begin
      r = lvl;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_path_gen_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : enemy_path_gen_rom
// Description : Synchronous-read path ROM holding the x and y images for all
//               level segments. One-cycle read latency. The built-in image
//               places entry a at x=a, y=a+PATH_Y_BIAS; addresses beyond the
//               ROM depth read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_path_gen_rom
  import enemy_path_gen_pkg::*;
#(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 600
) (
  input  logic               pclk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [COORD_W-1:0] x_data,
  output logic [COORD_W-1:0] y_data
);

  logic [COORD_W-1:0] x_d, x_q;
  logic [COORD_W-1:0] y_d, y_q;

  // Path image lookup for the requested address.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (32'(addr) < DEPTH) begin
      x_d = COORD_W'(addr);
      y_d = COORD_W'(32'(addr) + PATH_Y_BIAS);
    end
  end

  // Registered read port: data appears the cycle after the address.
  always_ff @(posedge pclk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign x_data = x_q;
  assign y_data = y_q;

endmodule
`default_nettype wire

// File: rtl/enemy_path_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : enemy_path_gen
// Description : Multi-enemy formation path generator. A tick divider steps a
//               shared head index through the current level's ROM segment;
//               each enemy trails the head by a fixed phase offset. A scan
//               reads every channel into shadow registers, then all
//               coordinates are committed to the outputs in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_path_gen
  import enemy_path_gen_pkg::*;
#(
  parameter int unsigned N_EN       = 8,
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned SEG_LEN    = 150,
  parameter int unsigned MAX_LEVEL  = 4,
  parameter int unsigned PHASE_STEP = 18,
  parameter int unsigned TICK_DIV   = 1000000
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [LEVEL_W-1:0]        level,
  input  logic                      freeze,
  input  logic [N_EN-1:0]           alive,
  output logic [N_EN*COORD_W-1:0]   x_flat,
  output logic [N_EN*COORD_W-1:0]   y_flat,
  output logic [N_EN-1:0]           en_valid,
  output logic                      frame_upd,
  output logic                      lap_done
);

  localparam int unsigned CH_W  = (N_EN > 1) ? $clog2(N_EN) : 1;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEPTH = SEG_LEN * MAX_LEVEL;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] SEG_LAST  = ADDR_W'(SEG_LEN - 1);
  localparam logic [ADDR_W-1:0] SEG_LEN_A = ADDR_W'(SEG_LEN);
  localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(PHASE_STEP);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_EN - 1);

  typedef logic [N_EN-1:0][COORD_W-1:0] coord_vec_t;

  scan_state_t          state_q, state_d;
  logic [CH_W-1:0]      ch_q,    ch_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [ADDR_W-1:0]    head_q,  head_d;
  logic [LEVEL_W-1:0]   lvl_q,   lvl_d;
  logic                 req_q,   req_d;
  coord_vec_t           xs_q,    xs_d;
  coord_vec_t           ys_q,    ys_d;
  coord_vec_t           xo_q,    xo_d;
  coord_vec_t           yo_q,    yo_d;
  logic [N_EN-1:0]      en_q,    en_d;
  logic                 fu_q,    fu_d;
  logic                 lap_q,   lap_d;

  logic [LEVEL_W-1:0]   lvl_eff;
  logic                 lvl_chg;
  logic                 tick;
  logic [ADDR_W-1:0]    seg_base;
  logic [ADDR_W-1:0]    ring_sum;
  logic [ADDR_W-1:0]    ring_idx;
  logic [ADDR_W-1:0]    rom_addr;
  logic [COORD_W-1:0]   rom_x;
  logic [COORD_W-1:0]   rom_y;

  assign lvl_eff = clamp_level(level, MAX_LEVEL);
  assign lvl_chg = (lvl_eff != lvl_q);
  assign tick    = !freeze && (cnt_q == CNT_LAST);

  // ROM address for the channel being scanned: head plus phase offset,
  // folded back into the segment, then rebased onto the latched level.
  always_comb begin
    seg_base = SEG_LEN_A * ADDR_W'(lvl_q - LEVEL_W'(1));
    ring_sum = head_q + ADDR_W'(ch_q) * STEP_A;
    ring_idx = (ring_sum >= SEG_LEN_A) ? (ring_sum - SEG_LEN_A) : ring_sum;
    rom_addr = seg_base + ring_idx;
  end

  enemy_path_gen_rom #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_rom (
    .pclk   (pclk),
    .addr   (rom_addr),
    .x_data (rom_x),
    .y_data (rom_y)
  );

  // Next-state logic: divider, head, level latch, scan sequencer, shadow
  // capture and output commit. A level change overrides everything else.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    lvl_d   = lvl_q;
    req_d   = req_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    en_d    = en_q;
    fu_d    = 1'b0;
    lap_d   = 1'b0;

    if (lvl_chg) begin
      lvl_d   = lvl_eff;
      head_d  = '0;
      cnt_d   = '0;
      req_d   = 1'b0;
      state_d = ST_SCAN;
      ch_d    = '0;
    end else begin
      if (!freeze) begin
        cnt_d = tick ? '0 : (cnt_q + CNT_W'(1));
      end
      if (tick) begin
        if (head_q == SEG_LAST) begin
          head_d = '0;
          lap_d  = 1'b1;
        end else begin
          head_d = head_q + ADDR_W'(1);
        end
      end
      // A tick that lands while a scan is busy is remembered, not lost.
      if (tick && (state_q != ST_IDLE)) begin
        req_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick || req_q) begin
            state_d = ST_SCAN;
            ch_d    = '0;
            req_d   = 1'b0;
          end
        end
        ST_SCAN: begin
          // Data returning now belongs to the previous channel's address.
          if (ch_q != '0) begin
            xs_d[ch_q - CH_W'(1)] = rom_x;
            ys_d[ch_q - CH_W'(1)] = rom_y;
          end
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
        ST_DRAIN: begin
          xs_d[CH_LAST] = rom_x;
          ys_d[CH_LAST] = rom_y;
          state_d       = ST_COMMIT;
        end
        ST_COMMIT: begin
          // Dead channels keep their last coordinates; only the mask drops.
          for (int i = 0; i < int'(N_EN); i++) begin
            if (alive[i]) begin
              xo_d[i] = xs_q[i];
              yo_d[i] = ys_q[i];
            end
          end
          en_d    = alive;
          fu_d    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset leaves a scan pending.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      lvl_q   <= LEVEL_W'(1);
      req_q   <= 1'b1;
      xs_q    <= '0;
      ys_q    <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      en_q    <= '0;
      fu_q    <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      lvl_q   <= lvl_d;
      req_q   <= req_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      en_q    <= en_d;
      fu_q    <= fu_d;
      lap_q   <= lap_d;
    end
  end

  assign x_flat    = xo_q;
  assign y_flat    = yo_q;
  assign en_valid  = en_q;
  assign frame_upd = fu_q;
  assign lap_done  = lap_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_path_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_enemy_path_gen
// Description : Self-checking bench for enemy_path_gen: directed sequences,
//               a level table, and randomized inputs against an event-level
//               reference model of the formation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_path_gen;

  localparam int N_EN       = 4;
  localparam int COORD_W    = 11;
  localparam int ADDR_W     = 12;
  localparam int SEG_LEN    = 150;
  localparam int MAX_LEVEL  = 4;
  localparam int PHASE_STEP = 10;
  localparam int TICK_DIV   = 20;
  localparam int SCAN_LAT   = N_EN + 2;   // trigger edge -> commit edge

  logic                    pclk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [3:0]              level = 4'd1;
  logic                    freeze = 1'b0;
  logic [N_EN-1:0]         alive = '1;
  logic [N_EN*COORD_W-1:0] x_flat;
  logic [N_EN*COORD_W-1:0] y_flat;
  logic [N_EN-1:0]         en_valid;
  logic                    frame_upd;
  logic                    lap_done;

  enemy_path_gen #(
    .N_EN       (N_EN),
    .COORD_W    (COORD_W),
    .ADDR_W     (ADDR_W),
    .SEG_LEN    (SEG_LEN),
    .MAX_LEVEL  (MAX_LEVEL),
    .PHASE_STEP (PHASE_STEP),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .level     (level),
    .freeze    (freeze),
    .alive     (alive),
    .x_flat    (x_flat),
    .y_flat    (y_flat),
    .en_valid  (en_valid),
    .frame_upd (frame_upd),
    .lap_done  (lap_done)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (event level) ----------------
  int              m_edge, m_head, m_cnt, m_lvl, m_commit, m_snap_head, m_snap_lvl;
  int              exp_x [N_EN];
  int              exp_y [N_EN];
  logic [N_EN-1:0] exp_en;
  bit              exp_fu, exp_lap;

  function automatic int eff_level(input int lv);
    if (lv == 0) return 1;
    if (lv > MAX_LEVEL) return MAX_LEVEL;
    return lv;
  endfunction

  function automatic int path_pos(input int h, input int lv, input int ch);
    return (lv - 1) * SEG_LEN + (h + ch * PHASE_STEP) % SEG_LEN;
  endfunction

  function automatic logic [N_EN*COORD_W-1:0] pack4(input int c0, input int c1,
                                                     input int c2, input int c3);
    return {11'(c3), 11'(c2), 11'(c1), 11'(c0)};
  endfunction

  task automatic schedule(input int e);
    m_commit    = e + SCAN_LAT;
    m_snap_head = m_head;
    m_snap_lvl  = m_lvl;
  endtask

  task automatic model_reset();
    m_edge = 0; m_head = 0; m_cnt = 0; m_lvl = 1;
    m_commit = 1 + SCAN_LAT; m_snap_head = 0; m_snap_lvl = 1;
    for (int i = 0; i < N_EN; i++) begin exp_x[i] = 0; exp_y[i] = 0; end
    exp_en = '0; exp_fu = 0; exp_lap = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int lv;
    m_edge++;
    exp_fu  = 0;
    exp_lap = 0;
    lv = eff_level(int'(level));
    if (lv != m_lvl) begin
      m_lvl = lv; m_head = 0; m_cnt = 0;
      schedule(m_edge);
    end else begin
      if (m_edge == m_commit) begin
        for (int i = 0; i < N_EN; i++) begin
          if (alive[i]) begin
            exp_x[i] = path_pos(m_snap_head, m_snap_lvl, i);
            exp_y[i] = exp_x[i] + 1000;
          end
        end
        exp_en   = alive;
        exp_fu   = 1;
        m_commit = -1;
      end
      if (!freeze) begin
        if (m_cnt == TICK_DIV - 1) begin
          m_cnt = 0;
          if (m_head == SEG_LEN - 1) begin m_head = 0; exp_lap = 1; end
          else m_head++;
          schedule(m_edge);
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N_EN*COORD_W-1:0] ex, ey;
    for (int i = 0; i < N_EN; i++) begin
      ex[i*COORD_W +: COORD_W] = COORD_W'(exp_x[i]);
      ey[i*COORD_W +: COORD_W] = COORD_W'(exp_y[i]);
    end
    n_vec++;
    if (x_flat !== ex || y_flat !== ey || en_valid !== exp_en ||
        frame_upd !== exp_fu || lap_done !== exp_lap) begin
      n_err++;
      $display("FAIL model edge %0d: x %h/%h y %h/%h en %b/%b fu %b/%b lap %b/%b (got/expected)",
               m_edge, x_flat, ex, y_flat, ey, en_valid, exp_en, frame_upd, exp_fu, lap_done, exp_lap);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge pclk);
    #1;
    check_all();
  endtask

  task automatic wait_fu(input int max_cyc, input string name);
    int k;
    k = 0;
    do begin step(); k++; end while (frame_upd !== 1'b1 && k < max_cyc);
    check_val(name, 64'(frame_upd), 64'd1);
  endtask

  typedef struct { logic [3:0] lvl; int x0; int x3; } lvl_vec_t;
  lvl_vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int laps, fu_cnt, held, k;
    bit found;
    logic [N_EN*COORD_W-1:0] xb, yb;

    tbl[0] = '{4'd0,  0,   30};
    tbl[1] = '{4'd9,  450, 480};
    tbl[2] = '{4'd2,  150, 180};
    tbl[3] = '{4'd15, 450, 480};
    tbl[4] = '{4'd3,  300, 330};
    tbl[5] = '{4'd5,  450, 480};
    tbl[6] = '{4'd1,  0,   30};

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_val("reset x_flat", 64'(x_flat), 64'd0);
    check_val("reset en_valid", 64'(en_valid), 64'd0);
    check_val("reset frame_upd", 64'(frame_upd), 64'd0);
    rst_n = 1'b1;
    model_reset();

    // 1: first commit seven edges after release
    for (int i = 0; i < 6; i++) step();
    check_val("t1 no early frame_upd", 64'(frame_upd), 64'd0);
    step();
    check_val("t1 frame_upd", 64'(frame_upd), 64'd1);
    check_val("t1 x", 64'(x_flat), 64'(pack4(0, 10, 20, 30)));
    check_val("t1 y", 64'(y_flat), 64'(pack4(1000, 1010, 1020, 1030)));
    check_val("t1 en_valid", 64'(en_valid), 64'hF);

    // 2: level 2, three ticks
    level = 4'd2;
    wait_fu(12, "t2 level commit");
    for (int t = 0; t < 3; t++) wait_fu(30, "t2 tick commit");
    check_val("t2 x", 64'(x_flat), 64'(pack4(153, 163, 173, 183)));

    // 3: wrap at the end of the segment
    level = 4'd1;
    wait_fu(12, "t3 level commit");
    for (int t = 0; t < 149; t++) wait_fu(30, "t3 tick commit");
    check_val("t3 x at head 149", 64'(x_flat), 64'(pack4(149, 9, 19, 29)));
    laps = 0;
    for (int i = 0; i < 30; i++) begin step(); if (lap_done) laps++; end
    check_val("t3 lap pulses", 64'(laps), 64'd1);
    check_val("t3 x after wrap", 64'(x_flat), 64'(pack4(0, 10, 20, 30)));

    // 4: level change in the middle of a scan
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_commit - m_edge == 4) found = 1;
    end
    check_val("t4 reached mid-scan", 64'(found), 64'd1);
    level = 4'd3;
    wait_fu(12, "t4 restart commit");
    check_val("t4 x", 64'(x_flat), 64'(pack4(300, 310, 320, 330)));

    // Level clamp table
    for (int v = 0; v < 7; v++) begin
      level = tbl[v].lvl;
      wait_fu(12, "tbl commit");
      check_val("tbl x0", 64'(x_flat[0 +: COORD_W]), 64'(tbl[v].x0));
      check_val("tbl x3", 64'(x_flat[3*COORD_W +: COORD_W]), 64'(tbl[v].x3));
    end

    // 5: freeze while idle
    wait_fu(30, "t5 pre-freeze commit");
    repeat (3) step();
    freeze = 1'b1;
    xb = x_flat;
    fu_cnt = 0;
    for (int i = 0; i < 100; i++) begin step(); if (frame_upd) fu_cnt++; end
    check_val("t5 frame_upd during freeze", 64'(fu_cnt), 64'd0);
    check_val("t5 x held", 64'(x_flat), 64'(xb));
    held = m_cnt;
    freeze = 1'b0;
    k = 0;
    do begin step(); k++; end while (frame_upd !== 1'b1 && k < 60);
    check_val("t5 release latency", 64'(k), 64'(TICK_DIV - held + SCAN_LAT));

    // 6: alive mask applied at commit
    xb = x_flat;
    yb = y_flat;
    step();
    alive = 4'b1010;
    wait_fu(30, "t6 commit");
    check_val("t6 en_valid", 64'(en_valid), 64'hA);
    check_val("t6 x ch0 kept", 64'(x_flat[0 +: COORD_W]), 64'(xb[0 +: COORD_W]));
    check_val("t6 x ch2 kept", 64'(x_flat[2*COORD_W +: COORD_W]), 64'(xb[2*COORD_W +: COORD_W]));
    check_val("t6 y ch0 kept", 64'(y_flat[0 +: COORD_W]), 64'(yb[0 +: COORD_W]));
    alive = '1;

    // Randomized inputs against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 199) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      if ($urandom_range(0, 9) == 0) alive = 4'($urandom);
    end
    freeze = 1'b0;
    alive  = '1;

    // Reset asserted mid-scan
    level = 4'd1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (m_commit - m_edge == 3) found = 1;
    end
    check_val("t6 reached mid-scan", 64'(found), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t6 async x", 64'(x_flat), 64'd0);
    check_val("t6 async y", 64'(y_flat), 64'd0);
    check_val("t6 async en_valid", 64'(en_valid), 64'd0);
    check_val("t6 async pulses", 64'({frame_upd, lap_done}), 64'd0);
    repeat (2) @(posedge pclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) step();
    check_val("t6 post-reset frame_upd", 64'(frame_upd), 64'd1);
    check_val("t6 post-reset x", 64'(x_flat), 64'(pack4(0, 10, 20, 30)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
